// File: rtl/bp_clint_responder_if.sv
// Command/response bus between the core's uncached load/store path and the CLINT responder.
// The master drives commands and consumes responses; the slave is the CLINT.
interface bp_clint_responder_if #(
    parameter int unsigned paddr_width_p = 40
);
    logic                     cmd_v;
    logic                     cmd_ready;
    logic [paddr_width_p-1:0] cmd_addr;
    logic                     cmd_write;
    logic [1:0]               cmd_size;
    logic [63:0]              cmd_data;
    logic                     resp_v;
    logic                     resp_yumi;
    logic [63:0]              resp_data;

    modport master (
        output cmd_v, cmd_addr, cmd_write, cmd_size, cmd_data, resp_yumi,
        input  cmd_ready, resp_v, resp_data
    );

    modport slave (
        input  cmd_v, cmd_addr, cmd_write, cmd_size, cmd_data, resp_yumi,
        output cmd_ready, resp_v, resp_data
    );
endinterface

// File: rtl/bp_clint_responder.sv
// Single-core CLINT target: mipi, mtimecmp, mtime and interrupt lines, one response per command.
// Define BP_CLINT_PLIC_EN to add the one-bit plic register at 0x0030_b000.
module bp_clint_responder #(
    parameter int unsigned paddr_width_p  = 40,
    parameter int unsigned timebase_div_p = 1
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    bp_clint_responder_if.slave   bus,
    output logic                  software_irq_o,
    output logic                  timer_irq_o,
    output logic                  external_irq_o
);

    localparam logic [paddr_width_p-1:0] MipiAddr     = paddr_width_p'(64'h0030_0000);
    localparam logic [paddr_width_p-1:0] MtimecmpAddr = paddr_width_p'(64'h0030_4000);
    localparam logic [paddr_width_p-1:0] MtimeAddr    = paddr_width_p'(64'h0030_bff8);
`ifdef BP_CLINT_PLIC_EN
    localparam logic [paddr_width_p-1:0] PlicAddr     = paddr_width_p'(64'h0030_b000);
`endif

    typedef enum logic [0:0] {StIdle, StResp} state_e;

    state_e      state_q;
    logic [63:0] mtime_q;
    logic [63:0] mtimecmp_q;
    logic [63:0] resp_data_q;
    logic [31:0] presc_q;
    logic        mipi_q;
    logic        timer_irq_q;
`ifdef BP_CLINT_PLIC_EN
    logic        plic_q;
    logic        sel_plic;
`endif

    logic                     accept;
    logic                     store;
    logic                     tick;
    logic [paddr_width_p-1:0] addr_aligned;
    logic [2:0]               off;
    logic                     sel_mipi;
    logic                     sel_mtimecmp;
    logic                     sel_mtime;
    logic [7:0]               size_mask;
    logic [7:0]               byte_mask;
    logic [63:0]              wbits;
    logic [63:0]              lmask;
    logic [63:0]              wdata;
    logic [63:0]              rsel;
    logic [63:0]              rdata;
    logic [63:0]              mtime_wr;
    logic [63:0]              mtimecmp_wr;

    assign accept       = bus.cmd_v & bus.cmd_ready;
    assign store        = accept & bus.cmd_write;
    assign tick         = (presc_q == timebase_div_p - 1);
    assign addr_aligned = {bus.cmd_addr[paddr_width_p-1:3], 3'b000};
    assign off          = bus.cmd_addr[2:0];
    assign sel_mipi     = (addr_aligned == MipiAddr);
    assign sel_mtimecmp = (addr_aligned == MtimecmpAddr);
    assign sel_mtime    = (addr_aligned == MtimeAddr);
`ifdef BP_CLINT_PLIC_EN
    assign sel_plic     = (addr_aligned == PlicAddr);
`endif

    always_comb begin
        size_mask = 8'h00;
        unique case (bus.cmd_size)
            2'd0: size_mask = 8'h01;
            2'd1: size_mask = 8'h03;
            2'd2: size_mask = 8'h0f;
            2'd3: size_mask = 8'hff;
        endcase
    end

    // Lanes shifted past byte 7 fall off the 8-bit mask.
    assign byte_mask = size_mask << off;
    assign wdata     = bus.cmd_data << {off, 3'b000};

    always_comb begin
        wbits = '0;
        lmask = '0;
        for (int i = 0; i < 8; i++) begin
            wbits[8*i +: 8] = {8{byte_mask[i]}};
            lmask[8*i +: 8] = {8{size_mask[i]}};
        end
    end

    assign mtime_wr    = (mtime_q & ~wbits) | (wdata & wbits);
    assign mtimecmp_wr = (mtimecmp_q & ~wbits) | (wdata & wbits);

    always_comb begin
        rsel = '0;
        if (sel_mipi) begin
            rsel = {63'b0, mipi_q};
        end else if (sel_mtimecmp) begin
            rsel = mtimecmp_q;
        end else if (sel_mtime) begin
            rsel = mtime_q;
`ifdef BP_CLINT_PLIC_EN
        end else if (sel_plic) begin
            rsel = {63'b0, plic_q};
`endif
        end
    end

    assign rdata = (rsel >> {off, 3'b000}) & lmask;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            mtime_q     <= '0;
            mtimecmp_q  <= '1;
            resp_data_q <= '0;
            presc_q     <= '0;
            mipi_q      <= 1'b0;
            timer_irq_q <= 1'b0;
`ifdef BP_CLINT_PLIC_EN
            plic_q      <= 1'b0;
`endif
        end else begin
            presc_q <= tick ? '0 : presc_q + 32'd1;

            // A store to mtime overrides the increment; the prescaler keeps running.
            if (store && sel_mtime) begin
                mtime_q <= mtime_wr;
            end else if (tick) begin
                mtime_q <= mtime_q + 64'd1;
            end

            if (store && sel_mtimecmp) begin
                mtimecmp_q <= mtimecmp_wr;
            end
            if (store && sel_mipi && byte_mask[0]) begin
                mipi_q <= wdata[0];
            end
`ifdef BP_CLINT_PLIC_EN
            if (store && sel_plic && byte_mask[0]) begin
                plic_q <= wdata[0];
            end
`endif

            timer_irq_q <= (mtime_q >= mtimecmp_q);

            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        state_q     <= StResp;
                        resp_data_q <= bus.cmd_write ? 64'd0 : rdata;
                    end
                end
                StResp: begin
                    if (bus.resp_yumi) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Ready is masked by reset so it is low during reset and high right after release.
    assign bus.cmd_ready  = (state_q == StIdle) & ~reset_i;
    assign bus.resp_v     = (state_q == StResp);
    assign bus.resp_data  = resp_data_q;
    assign software_irq_o = mipi_q;
    assign timer_irq_o    = timer_irq_q;
`ifdef BP_CLINT_PLIC_EN
    assign external_irq_o = plic_q;
`else
    assign external_irq_o = 1'b0;
`endif

endmodule
